// File: rtl/sd_sector_reader.sv
// SD card single-sector reader (CMD17) driving an external SPI byte engine.
// Streams the 512 data bytes into a sector buffer and reports one status code per read.
module sd_sector_reader #(
    parameter int unsigned TOKEN_TIMEOUT = 4095,
    parameter int unsigned R1_TRIES      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] lba,
    input  logic        sdhc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        cs_n,
    output logic [7:0]  spi_tx,
    output logic        spi_start,
    input  logic        spi_ready,
    input  logic [7:0]  spi_rx,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [7:0]  buf_data
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned R1_W  = 4;
    localparam int unsigned TOK_W = 12;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_R1    = 3'd2;
    localparam logic [2:0] S_TOKEN = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_CRC   = 3'd5;
    localparam logic [2:0] S_TAIL  = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    localparam logic [2:0] E_NO_R1     = 3'd1;
    localparam logic [2:0] E_R1        = 3'd2;
    localparam logic [2:0] E_TOKEN_TMO = 3'd3;
    localparam logic [2:0] E_BAD_TOKEN = 3'd4;

    localparam logic [R1_W-1:0]  R1_LAST  = R1_W'(R1_TRIES - 1);
    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(TOKEN_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [R1_W-1:0]  r1_cnt_q, r1_cnt_d;
    logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
    logic             inflight_q, inflight_d;
    logic             ign_q, ign_d;
    logic             spi_start_q, spi_start_d;
    logic [7:0]       spi_tx_q, spi_tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             cs_n_q, cs_n_d;
    logic             buf_we_q, buf_we_d;
    logic [8:0]       buf_addr_q, buf_addr_d;
    logic [7:0]       buf_data_q, buf_data_d;

    logic             byte_done;
    logic             need_byte;
    logic             fail;
    logic [2:0]       fail_code;
    logic [7:0]       tx_byte;

    // Next-state, byte sequencing and output decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        r1_cnt_d    = r1_cnt_q;
        tok_cnt_d   = tok_cnt_q;
        inflight_d  = inflight_q;
        ign_d       = spi_start_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        fail        = 1'b0;
        fail_code   = 3'd0;
        need_byte   = 1'b0;
        tx_byte     = 8'hFF;

        // A byte finishes on the first ready after the ignore cycle that follows spi_start
        byte_done = inflight_q && !spi_start_q && !ign_q && spi_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CMD;
                    addr_d     = sdhc ? lba : {lba[22:0], 9'b0};
                    err_d      = 1'b0;
                    err_code_d = 3'd0;
                    cnt_d      = '0;
                    r1_cnt_d   = '0;
                    tok_cnt_d  = '0;
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    if (cnt_q == CNT_W'(5)) begin
                        state_d = S_R1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
            end
            S_R1: begin
                if (byte_done) begin
                    if (!spi_rx[7]) begin
                        if (spi_rx == 8'h00) begin
                            state_d = S_TOKEN;
                        end else begin
                            fail      = 1'b1;
                            fail_code = E_R1;
                        end
                    end else if (r1_cnt_q == R1_LAST) begin
                        fail      = 1'b1;
                        fail_code = E_NO_R1;
                    end else if (r1_cnt_q != '1) begin
                        r1_cnt_d = R1_W'(r1_cnt_q + R1_W'(1));
                    end
                end
            end
            S_TOKEN: begin
                if (byte_done) begin
                    if (spi_rx == 8'hFE) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else if (spi_rx != 8'hFF) begin
                        fail      = 1'b1;
                        fail_code = E_BAD_TOKEN;
                    end else if (tok_cnt_q == TOK_LAST) begin
                        fail      = 1'b1;
                        fail_code = E_TOKEN_TMO;
                    end else if (tok_cnt_q != '1) begin
                        tok_cnt_d = TOK_W'(tok_cnt_q + TOK_W'(1));
                    end
                end
            end
            S_DATA: begin
                if (byte_done) begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = cnt_q;
                    buf_data_d = spi_rx;
                    if (cnt_q == CNT_W'(511)) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
            end
            S_CRC: begin
                if (byte_done) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_TAIL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
            end
            S_TAIL: begin
                if (byte_done) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail) begin
            state_d    = S_TAIL;
            cnt_d      = '0;
            err_d      = 1'b1;
            err_code_d = fail_code;
        end

        // Command frame bytes; every other byte on the bus is a 0xFF poll/clock byte
        if (state_q == S_CMD) begin
            case (cnt_q[2:0])
                3'd0:    tx_byte = 8'h51;
                3'd1:    tx_byte = addr_q[31:24];
                3'd2:    tx_byte = addr_q[23:16];
                3'd3:    tx_byte = addr_q[15:8];
                3'd4:    tx_byte = addr_q[7:0];
                default: tx_byte = 8'hFF;
            endcase
        end

        // TAIL sends exactly one byte; cnt_q marks it as issued
        need_byte = (state_q inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC}) ||
                    (state_q == S_TAIL && cnt_q == '0);

        if (need_byte && !inflight_q && spi_ready) begin
            spi_start_d = 1'b1;
            spi_tx_d    = tx_byte;
            inflight_d  = 1'b1;
            if (state_q == S_TAIL) begin
                cnt_d = CNT_W'(1);
            end
        end else if (byte_done) begin
            inflight_d = 1'b0;
        end

        busy_d = state_d inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL};
        done_d = (state_d == S_FIN);
        cs_n_d = !(state_d inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            r1_cnt_q    <= '0;
            tok_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            ign_q       <= 1'b0;
            spi_start_q <= 1'b0;
            spi_tx_q    <= 8'hFF;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            cs_n_q      <= 1'b1;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            r1_cnt_q    <= r1_cnt_d;
            tok_cnt_q   <= tok_cnt_d;
            inflight_q  <= inflight_d;
            ign_q       <= ign_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cs_n_q      <= cs_n_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign cs_n      = cs_n_q;
    assign spi_tx    = spi_tx_q;
    assign spi_start = spi_start_q;
    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_data  = buf_data_q;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: SPI byte engine + SD card model, scoreboard of buffer writes,
// table of read scenarios plus a reset-mid-sector sequence.
module tb_sd_sector_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] lba;
    logic        sdhc;
    logic        busy, done, err;
    logic [2:0]  err_code;
    logic        cs_n;
    logic [7:0]  spi_tx;
    logic        spi_start;
    logic        spi_ready;
    logic [7:0]  spi_rx;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;

    sd_sector_reader dut (
        .clk(clk), .reset(reset), .start(start), .lba(lba), .sdhc(sdhc),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .cs_n(cs_n),
        .spi_tx(spi_tx), .spi_start(spi_start), .spi_ready(spi_ready), .spi_rx(spi_rx),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lba;
        logic        sdhc;
        int          r1_at;    // poll index carrying R1, -1 = never
        logic [7:0]  r1v;
        int          tok;      // 0xFF polls before token, -1 = never
        logic [7:0]  tokv;
        logic [7:0]  xr;       // data byte n = n[7:0] ^ xr
        logic [47:0] cmd;
        logic        err;
        logic [2:0]  code;
        int          nwe;
        int          nbytes;
    } row_t;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } we_t;

    row_t       rows[8];
    row_t       cur;
    we_t        exp_q[$];
    logic [7:0] cmd_q[$];

    int total = 0;
    int bad   = 0;
    int cyc = 0, k = 0, nbytes = 0, nwe = 0, ndone = 0, n_cs_hi = 0;
    int last_compl = 0, stage = 0, lat = 0, dd = 0;
    logic       last_cs = 1'b0;
    logic       push_en = 1'b0;
    logic [7:0] rv = 8'hFF;
    we_t        e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // SD card response for transfer index kk of the current read
    task automatic sd_resp(input int kk, output logic [7:0] v, output int d);
        int p, q;
        v = 8'hFF;
        d = -1;
        if (kk >= 6 && cur.r1_at >= 0) begin
            p = kk - 6;
            if (p == cur.r1_at) v = cur.r1v;
            else if (p > cur.r1_at && cur.tok >= 0) begin
                q = p - cur.r1_at - 1;
                if (q == cur.tok) v = cur.tokv;
                else if (q > cur.tok) begin
                    d = q - cur.tok - 1;
                    if (d < 512) v = 8'(d) ^ cur.xr;
                    else d = -1;
                end
            end
        end
    endtask

    // Byte engine model and output monitor
    initial begin
        spi_ready = 1'b1;
        spi_rx    = 8'hFF;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                stage     = 0;
                spi_ready = 1'b1;
                spi_rx    = 8'hFF;
            end else begin
                if (buf_we) begin
                    nwe++;
                    chk("we_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("buf_addr", 32'(buf_addr), 32'(e.addr));
                        chk("buf_data", 32'(buf_data), 32'(e.data));
                        chk("we_timing", cyc, last_compl + 1);
                    end
                end
                if (done) begin
                    ndone++;
                    chk("busy_at_done", 32'(busy), 0);
                    chk("cs_n_at_done", 32'(cs_n), 1);
                end
                if (spi_start) begin
                    chk("start_when_ready", 32'(stage == 0 && spi_ready), 1);
                    nbytes++;
                    if (cs_n) n_cs_hi++;
                    last_cs = cs_n;
                    if (cmd_q.size() != 0) chk("cmd_byte", 32'(spi_tx), 32'(cmd_q.pop_front()));
                    else chk("poll_tx", 32'(spi_tx), 32'hFF);
                    sd_resp(k, rv, dd);
                    k++;
                    if (dd >= 0 && push_en) exp_q.push_back(we_t'{9'(dd), rv});
                    stage = 1;
                end else if (stage == 1) begin
                    // ready stays stale-high here; the reader must ignore it
                    stage = 2;
                    lat   = $urandom_range(0, 1);
                end else if (stage == 2) begin
                    if (lat > 0) begin
                        spi_ready = 1'b0;
                        lat--;
                    end else begin
                        spi_ready  = 1'b1;
                        spi_rx     = rv;
                        stage      = 0;
                        last_compl = cyc;
                    end
                end
            end
        end
    end

    task automatic prep(input row_t r);
        logic [47:0] c;
        logic [7:0]  cb;
        cur = r;
        k = 0; nbytes = 0; nwe = 0; ndone = 0; n_cs_hi = 0; last_cs = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        push_en = !r.err;
        c = r.cmd;
        for (int b = 0; b < 6; b++) begin
            cb = c[47 - 8*b -: 8];
            cmd_q.push_back(cb);
        end
    endtask

    task automatic run_row(input row_t r, input int idx);
        int got;
        prep(r);
        lba = r.lba; sdhc = r.sdhc; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        repeat (10) @(posedge clk);
        #2;
        lba = 32'h99; sdhc = ~r.sdhc; start = 1'b1;   // must be ignored while busy
        @(posedge clk); #2;
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 40000 && got == 0; c++) begin
            @(posedge clk); #2;
            if (done) got = 1;
        end
        chk("done_seen", 32'(got), 1);
        start = 1'b1;                                 // coincides with FIN: must be ignored
        chk("err", 32'(err), 32'(r.err));
        chk("err_code", 32'(err_code), 32'(r.code));
        @(posedge clk); #2;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("nbytes", nbytes, r.nbytes);
        chk("n_buf_we", nwe, r.nwe);
        chk("done_once", ndone, 1);
        chk("cs_hi_only_tail", 32'(n_cs_hi == 1 && last_cs == 1'b1), 1);
        chk("idle_after", 32'(busy), 0);
        chk("err_hold", 32'(err), 32'(r.err));
        chk("code_hold", 32'(err_code), 32'(r.code));
        chk("we_left", 32'(exp_q.size()), 0);
        chk("cmd_left", 32'(cmd_q.size()), 0);
        if (idx < 0) $display("row rerun complete");
    endtask

    task automatic reset_seq();
        row_t r;
        int   got, w0;
        r = rows[0];
        r.lba = 32'h20;
        r.xr  = 8'h33;
        r.cmd = 48'h51_00_00_00_20_FF;
        prep(r);
        lba = r.lba; sdhc = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 10000 && got == 0; c++) begin
            @(posedge clk); #2;
            if (nwe >= 100) got = 1;
        end
        chk("reach_byte100", 32'(got), 1);
        push_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_buf_we", 32'(buf_we), 0);
        chk("rst_spi_start", 32'(spi_start), 0);
        chk("rst_spi_tx", 32'(spi_tx), 32'hFF);
        chk("rst_buf_addr", 32'(buf_addr), 0);
        reset = 1'b0;
        exp_q.delete();
        w0 = nwe;
        repeat (60) @(posedge clk);
        #2;
        chk("no_we_after_rst", nwe, w0);
        chk("no_done_after_rst", ndone, 0);
        chk("idle_after_rst", 32'(busy), 0);
        chk("cs_after_rst", 32'(cs_n), 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; lba = '0; sdhc = 1'b0;
        //          lba            sdhc r1_at r1v    tok tokv   xr     cmd                      err code nwe  nbytes
        rows[0] = '{32'h10,        1'b1, 1, 8'h00,  3, 8'hFE, 8'h00, 48'h51_00_00_00_10_FF, 1'b0, 3'd0, 512, 527};
        rows[1] = '{32'h3,         1'b0, 0, 8'h00,  0, 8'hFE, 8'hA5, 48'h51_00_00_06_00_FF, 1'b0, 3'd0, 512, 523};
        rows[2] = '{32'h77,        1'b1, 0, 8'h04,  3, 8'hFE, 8'h00, 48'h51_00_00_00_77_FF, 1'b1, 3'd2, 0,   8};
        rows[3] = '{32'h1,         1'b1, -1, 8'h00, 0, 8'hFE, 8'h00, 48'h51_00_00_00_01_FF, 1'b1, 3'd1, 0,   15};
        rows[4] = '{32'h2,         1'b1, 0, 8'h00, -1, 8'hFE, 8'h00, 48'h51_00_00_00_02_FF, 1'b1, 3'd3, 0,   4103};
        rows[5] = '{32'h1234,      1'b1, 2, 8'h00,  1, 8'h08, 8'h00, 48'h51_00_00_12_34_FF, 1'b1, 3'd4, 0,   12};
        rows[6] = '{32'hDEADBEEF,  1'b1, 7, 8'h00,  0, 8'hFE, 8'h3C, 48'h51_DE_AD_BE_EF_FF, 1'b0, 3'd0, 512, 530};
        rows[7] = '{32'hFFFFFFFF,  1'b0, 7, 8'h7F,  3, 8'hFE, 8'h00, 48'h51_FF_FF_FE_00_FF, 1'b1, 3'd2, 0,   15};

        repeat (3) @(posedge clk);
        #2;
        chk("reset_cs_n", 32'(cs_n), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_err_code", 32'(err_code), 0);
        chk("reset_spi_start", 32'(spi_start), 0);
        chk("reset_spi_tx", 32'(spi_tx), 32'hFF);
        chk("reset_buf_we", 32'(buf_we), 0);
        chk("reset_buf_addr", 32'(buf_addr), 0);
        chk("reset_buf_data", 32'(buf_data), 0);
        reset = 1'b0;
        @(posedge clk); #2;

        for (int i = 0; i < 8; i++) run_row(rows[i], i);
        reset_seq();
        run_row(rows[0], -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
